io_avalon_event_interface: RTL
==============================

Name: io_avalon_event_interface

Overview:
Parametrised successor of the gamepad Avalon-MM input block. Serves NUM_PADS controllers of INPUTS_PER_PAD lines each. Every line is synchronised and debounced. Each debounced edge is queued as a timestamped event in a FIFO that the HPS reads through a 4-register Avalon-MM slave. A level IRQ is driven by FIFO occupancy and overflow.

Parameters:
NUM_PADS, 2, number of controllers (1..4).
INPUTS_PER_PAD, 12, lines per controller; per pad {DOWN,UP,RIGHT,LEFT,X,Y,A,B,TR,TL,START,SELECT}, pad 0 in LSBs; NUM_PADS*INPUTS_PER_PAD <= 64.
DEBOUNCE_CYCLES, 50000, stable cycles required before a level is accepted (>=2).
FIFO_DEPTH, 16, event FIFO entries (power of 2, 4..256).
TICK_CYCLES, 50000, clocks per timestamp tick (1 ms at 50 MHz).
DATA_WIDTH, 64, Avalon data width (fixed 64).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; synchronous, active-low.
pad_in  in  NUM_PADS*INPUTS_PER_PAD  raw active-high inputs, asynchronous.
address  in  2  register select: 0 STATUS, 1 STATE, 2 EVENT, 3 CTRL.
read  in  1  Avalon read strobe.
write  in  1  Avalon write strobe.
writedata  in  64  write data.
readdata  out  64  read data, registered.
waitrequest  out  1  Avalon wait.
irq  out  1  level interrupt.
leds  out  8  LED drive from CTRL.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears: synchronisers, debounce counters, debounced levels (0), pending flags, FIFO pointers and count, overflow, timestamp, CTRL, readdata, and the read FSM. Outputs then read readdata=0, waitrequest=0, irq=0, leds=0. A reset during an access aborts it. A pending pop is not performed.
- Input path: 2-FF synchroniser per line, then a per-line counter. The counter clears whenever the synchronised value equals the debounced level. When they differ, the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value and the line's pending flag sets.
- Arbiter: each cycle, the lowest-index pending line pushes one event and its pending flag clears. A line that toggles again while pending keeps a single flag; its event carries the level current at push time.
- Event word: [63] valid=1, [47:32] timestamp, [23:16] pad index, [15:8] line index within pad, [0] level. Other bits are 0.
- Timestamp: 16-bit counter, increments once every TICK_CYCLES clocks, wraps 0xFFFF->0.
- FIFO full on push: the event is dropped, the flag is still cleared, and STATUS.overflow sets (sticky). A push and a pop in the same cycle while full both occur, with no overflow. A pop while empty returns 0 (valid=0) with no state change.
- Read FSM, IDLE -> RESP -> IDLE:
  - IDLE with read=1: waitrequest=1 that cycle, and readdata loads the selected register.
  - RESP: waitrequest=0 and readdata is held. The master samples in RESP. Fixed latency is 1 wait state.
  - An EVENT read pops the FIFO on the IDLE->RESP edge.
  - read and write together: write wins, and the read is ignored.
- Writes complete in one cycle with waitrequest=0. Writes to STATUS, STATE and EVENT are ignored.
- STATUS read: [8:0] FIFO count, [16] overflow, [17] irq, [18] FIFO empty.
- STATE read: all debounced levels packed in the low bits. Upper bits are 0.
- CTRL (read/write): [0] irq_en, [15:8] leds, [23:16] irq_threshold (0 treated as 1). Write bit [31]=1 clears overflow; [31] is not stored and reads 0.
- irq is registered: irq = irq_en & ((count >= threshold) | overflow). It drops the cycle after the condition clears.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles while pad_in=all-ones -> all outputs 0. With DEBOUNCE_CYCLES=4 and pad_in held, 24 events are queued, each with level=1, pad/line order 0/0..1/11; STATUS count=16 and overflow=1 (FIFO_DEPTH=16).
- Debounce: with DEBOUNCE_CYCLES=4, a 3-cycle pulse on line 5 gives no event and STATE=0. A 4+-cycle pulse gives one event {pad0,line5,level1}, then one with level0 after release.
- Read latency: read EVENT -> waitrequest=1 for exactly 1 cycle. readdata valid next cycle with bit63=1. Count decrements by 1. Reading an empty FIFO returns 0.
- IRQ: CTRL=0x0000_0000_0003_0001 (threshold 3, en). Generate 3 events -> irq rises after the 3rd push. Pop 1 -> irq falls the next cycle.
- Overflow: fill with 17 events -> overflow=1 and count=16, irq=1 when enabled. Write CTRL bit31 -> overflow=0, other CTRL fields keep the written value.
- Reset mid-read: assert rst_n=0 in the RESP cycle of an EVENT read -> next cycle readdata=0, waitrequest=0, FIFO empty.

Source files
------------

// File: rtl/io_avalon_event_interface.sv
// Debounced pad inputs queued as timestamped events in a FIFO, read over Avalon-MM.
// A level IRQ fires on FIFO occupancy or overflow.
module io_avalon_event_interface #(
  parameter int unsigned NUM_PADS        = 2,
  parameter int unsigned INPUTS_PER_PAD  = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned TICK_CYCLES     = 50000,
  parameter int unsigned DATA_WIDTH      = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PADS*INPUTS_PER_PAD-1:0]   pad_in,
  input  logic [1:0]                           address,
  input  logic                                 read,
  input  logic                                 write,
  input  logic [DATA_WIDTH-1:0]                writedata,
  output logic [DATA_WIDTH-1:0]                readdata,
  output logic                                 waitrequest,
  output logic                                 irq,
  output logic [7:0]                           leds
);

  localparam int unsigned NumLines = NUM_PADS * INPUTS_PER_PAD;
  localparam int unsigned CntW     = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AddrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned TickW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [CntW-1:0]  DebMax  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_CYCLES - 1);
  localparam logic [AddrW:0]   FullCnt = (AddrW + 1)'(FIFO_DEPTH);

  typedef enum logic {StIdle, StResp} rd_state_e;

  // Input path
  logic [NumLines-1:0] sync1_q, sync2_q;
  logic [NumLines-1:0] deb_q, deb_d;
  logic [NumLines-1:0] pend_q, pend_d;
  logic [CntW-1:0]     cnt_q [NumLines];
  logic [CntW-1:0]     cnt_d [NumLines];

  // Arbiter
  logic [NumLines-1:0] grant;
  logic                push_req;
  logic [7:0]          ev_pad, ev_line;
  logic                ev_level;
  logic [63:0]         ev_word;

  // Timestamp
  logic [TickW-1:0] tick_q, tick_d;
  logic [15:0]      ts_q, ts_d;

  // FIFO
  logic [63:0]    mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             full, empty, do_push, do_pop, ovf_set;
  logic             ovf_q, ovf_d;

  // Control and bus
  logic       irq_en_q, irq_en_d;
  logic [7:0] leds_q, leds_d;
  logic [7:0] thr_q, thr_d, thr_eff;
  logic       irq_q, irq_d;
  rd_state_e  rd_st_q, rd_st_d;
  logic       rd_accept, ctrl_wr;
  logic [63:0] readdata_q, readdata_d;
  logic [63:0] status_word, state_word, ctrl_word;
  logic        unused_wdata;

  assign unused_wdata = ^{writedata[63:32], writedata[30:24], writedata[7:1]};

  // Debounce: a line must differ from its accepted level for DEBOUNCE_CYCLES edges.
  always_comb begin
    deb_d  = deb_q;
    pend_d = pend_q & ~grant;
    for (int i = 0; i < NumLines; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DebMax) begin
          deb_d[i]  = sync2_q[i];
          pend_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Lowest-index pending line wins; the event reports the level at push time.
  always_comb begin
    grant    = '0;
    push_req = 1'b0;
    ev_pad   = '0;
    ev_line  = '0;
    ev_level = 1'b0;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int l = 0; l < INPUTS_PER_PAD; l++) begin
        if (!push_req && pend_q[p*INPUTS_PER_PAD + l]) begin
          push_req                   = 1'b1;
          grant[p*INPUTS_PER_PAD + l] = 1'b1;
          ev_pad                     = 8'(p);
          ev_line                    = 8'(l);
          ev_level                   = deb_q[p*INPUTS_PER_PAD + l];
        end
      end
    end
  end

  assign ev_word = {1'b1, 15'b0, ts_q, 8'b0, ev_pad, ev_line, 7'b0, ev_level};

  always_comb begin
    tick_d = tick_q + 1'b1;
    ts_d   = ts_q;
    if (tick_q == TickMax) begin
      tick_d = '0;
      ts_d   = ts_q + 16'd1;
    end
  end

  assign rd_accept   = (rd_st_q == StIdle) && read && !write;
  assign waitrequest = rd_accept;
  assign ctrl_wr     = write && (address == 2'd3);

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_pop  = rd_accept && (address == 2'd2) && !empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push = push_req && (!full || do_pop);
  assign ovf_set = push_req && full && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    irq_en_d = irq_en_q;
    leds_d   = leds_q;
    thr_d    = thr_q;
    ovf_d    = ovf_q;
    if (ctrl_wr) begin
      irq_en_d = writedata[0];
      leds_d   = writedata[15:8];
      thr_d    = writedata[23:16];
      if (writedata[31]) ovf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
  end

  assign thr_eff = (thr_q == 8'd0) ? 8'd1 : thr_q;
  assign irq_d   = irq_en_q && (((9)'(count_q) >= {1'b0, thr_eff}) || ovf_q);

  always_comb begin
    status_word        = '0;
    status_word[8:0]   = 9'(count_q);
    status_word[16]    = ovf_q;
    status_word[17]    = irq_q;
    status_word[18]    = empty;
    state_word         = '0;
    state_word[NumLines-1:0] = deb_q;
    ctrl_word          = {40'b0, thr_q, leds_q, 7'b0, irq_en_q};
  end

  always_comb begin
    rd_st_d    = StIdle;
    readdata_d = readdata_q;
    if (rd_accept) begin
      rd_st_d = StResp;
      unique case (address)
        2'd0:    readdata_d = status_word;
        2'd1:    readdata_d = state_word;
        2'd2:    readdata_d = empty ? 64'd0 : mem_q[rd_ptr_q];
        default: readdata_d = ctrl_word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= ev_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      pend_q     <= '0;
      for (int i = 0; i < NumLines; i++) cnt_q[i] <= '0;
      tick_q     <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      leds_q     <= '0;
      thr_q      <= '0;
      irq_q      <= 1'b0;
      rd_st_q    <= StIdle;
      readdata_q <= '0;
    end else begin
      sync1_q    <= pad_in;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      pend_q     <= pend_d;
      for (int i = 0; i < NumLines; i++) cnt_q[i] <= cnt_d[i];
      tick_q     <= tick_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      leds_q     <= leds_d;
      thr_q      <= thr_d;
      irq_q      <= irq_d;
      rd_st_q    <= rd_st_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
  assign leds     = leds_q;

endmodule
